cpu_io_port: RTL and testbench

Peripheral on the far side of the CPU's `ent1..ent4` / `sal1..sal4` port bus for the memory game. It debounces four push buttons into a key-code register with a 4-phase handshake, and runs a countdown timer armed from a CPU output port. It also supplies a free-running pseudo-random byte and drives the LED bank from `sal1`. Status flags sit on bit 7 of `ent2` and `ent3`, where the CPU replicates them across the byte.

---
 rtl/cpu_io_pkg.sv | 23 ++
 rtl/io_debounce.sv | 55 +++++
 rtl/cpu_io_port.sv | 167 ++++++++++++++++
 tb/tb_cpu_io_port.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_io_pkg.sv
// Shared definitions for the memory-game CPU I/O port.
//   NumBtn   : number of push buttons
//   LfsrSeed : LFSR reset value
//   LfsrTaps : feedback tap mask (bits 7,5,4,3)
//   key_state_e : key handshake states
package cpu_io_pkg;

  localparam int unsigned NumBtn   = 4;
  localparam logic [7:0]  LfsrSeed = 8'h01;
  localparam logic [7:0]  LfsrTaps = 8'hB8;

  typedef enum logic [1:0] {
    StIdle,
    StFull,
    StAck
  } key_state_e;

  // Fibonacci shift-left step: feedback is the parity of the tapped bits.
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ^(q & LfsrTaps)};
  endfunction

endpackage

// File: rtl/io_debounce.sv
// One push-button channel: 2-flop synchronizer, debouncer and press-event pulse.
//   clk, reset : clock, asynchronous active-high reset
//   btn_i      : raw button, asynchronous to clk
//   press_o    : one-cycle pulse on a debounced 0->1 transition
module io_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d, stable_prev_q;
  logic            press_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronized input disagrees with the
  // stable level; the level flips on the DEBOUNCE_CYCLES-th such cycle.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cnt_q         <= '0;
      press_q       <= 1'b0;
    end else begin
      sync1_q       <= btn_i;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      cnt_q         <= cnt_d;
      stable_prev_q <= stable_q;
      press_q       <= stable_q & ~stable_prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/cpu_io_port.sv
// CPU-side peripheral for the memory game.
//   clk, reset : clock, asynchronous active-high reset
//   btn        : raw push buttons (4)
//   sal1       : LED pattern          -> leds (registered)
//   sal2[0]    : key acknowledge
//   sal3       : [7] timer arm (rising edge), [6:0] tick count
//   sal4       : reserved
//   ent1       : {6'b0, key index}
//   ent2       : [7] key valid
//   ent3       : [7] timer expired
//   ent4       : LFSR state
// Configuration: define CPU_IO_LFSR_EN to build the LFSR; otherwise ent4 = 8'h00.
module cpu_io_port
  import cpu_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TICK_DIV        = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic [7:0] sal1,
  input  logic [7:0] sal2,
  input  logic [7:0] sal3,
  input  logic [7:0] sal4,
  output logic [7:0] ent1,
  output logic [7:0] ent2,
  output logic [7:0] ent3,
  output logic [7:0] ent4,
  output logic [7:0] leds
);

  localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic unused_inputs;
  assign unused_inputs = ^{sal4, sal2[7:1]};

  // Buttons
  logic [NumBtn-1:0] press;

  for (genvar g = 0; g < NumBtn; g++) begin : g_btn
    io_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .btn_i  (btn[g]),
      .press_o(press[g])
    );
  end

  // Key handshake
  key_state_e state_q, state_d;
  logic [1:0] code_q, code_d;
  logic [1:0] pick;

  always_comb begin
    pick = '0;
    for (int i = NumBtn - 1; i >= 0; i--) begin
      if (press[i]) pick = 2'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      StIdle: begin
        if (|press) begin
          state_d = StFull;
          code_d  = pick;
        end
      end
      StFull:  if (sal2[0])  state_d = StAck;
      StAck:   if (!sal2[0]) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  // Countdown timer
  logic            arm_prev_q, arm_edge;
  logic            run_q, run_d;
  logic            exp_q, exp_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [DivW-1:0] div_q, div_d;

  assign arm_edge = sal3[7] & ~arm_prev_q;

  // run_q marks an armed timer whose expiry has not yet been flagged; the
  // flag is raised one cycle after cnt reaches 0, which also covers a load of 0.
  always_comb begin
    run_d = run_q;
    exp_d = exp_q;
    cnt_d = cnt_q;
    div_d = div_q;
    if (arm_edge) begin
      cnt_d = sal3[6:0];
      div_d = '0;
      exp_d = 1'b0;
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == 7'd0) begin
        exp_d = 1'b1;
        run_d = 1'b0;
      end else if (div_q == DivW'(TICK_DIV - 1)) begin
        div_d = '0;
        cnt_d = cnt_q - 7'd1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_prev_q <= 1'b0;
      run_q      <= 1'b0;
      exp_q      <= 1'b0;
      cnt_q      <= '0;
      div_q      <= '0;
    end else begin
      arm_prev_q <= sal3[7];
      run_q      <= run_d;
      exp_q      <= exp_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
    end
  end

  // LEDs
  logic [7:0] leds_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) leds_q <= '0;
    else       leds_q <= sal1;
  end

  // Pseudo-random byte
`ifdef CPU_IO_LFSR_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= LfsrSeed;
    else       lfsr_q <= lfsr_next(lfsr_q);
  end

  assign ent4 = lfsr_q;
`else
  assign ent4 = 8'h00;
`endif

  assign ent1 = {6'b0, code_q};
  assign ent2 = {(state_q == StFull), 7'b0};
  assign ent3 = {exp_q, 7'b0};
  assign leds = leds_q;

endmodule

// File: tb/tb_cpu_io_port.sv
module tb_cpu_io_port;

  localparam int unsigned Deb  = 4;
  localparam int unsigned Tick = 10;
  // Ticks from driving a button until ent2[7] reads high: the first sampling
  // edge is one tick after the drive, then sync(2) + debounce + event + FSM - 1.
  localparam int KeyLat = 1 + 2 + Deb + 1 + 1 - 1;
`ifdef CPU_IO_LFSR_EN
  localparam logic [7:0] Ent4Rst = 8'h01;
`else
  localparam logic [7:0] Ent4Rst = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic [7:0] sal1, sal2, sal3, sal4;
  logic [7:0] ent1, ent2, ent3, ent4, leds;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_io_port #(
    .DEBOUNCE_CYCLES(Deb),
    .TICK_DIV       (Tick)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .btn  (btn),
    .sal1 (sal1),
    .sal2 (sal2),
    .sal3 (sal3),
    .sal4 (sal4),
    .ent1 (ent1),
    .ent2 (ent2),
    .ent3 (ent3),
    .ent4 (ent4),
    .leds (leds)
  );

  // Reference model pieces
  function automatic logic [1:0] ref_code(input logic [3:0] mask);
    for (int i = 0; i < 4; i++) if (mask[i]) return 2'(i);
    return 2'd0;
  endfunction

  function automatic logic [7:0] ref_lfsr(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  // Ticks from driving an arm edge on sal3 until ent3[7] reads high.
  function automatic int ref_timer_lat(input int n);
    return (n == 0) ? 2 : n * int'(Tick) + 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ent2(output int lat);
    lat = 0;
    while (ent2[7] !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic wait_ent3(inout int lat);
    while (ent3[7] !== 1'b1 && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (ent1 !== 8'h00 || ent2 !== 8'h00 || ent3 !== 8'h00 || leds !== 8'h00) begin
      failures++;
      $display("FAIL reset_outs got=%h/%h/%h/%h want=00/00/00/00", ent1, ent2, ent3, leds);
    end
    checks++;
    if (ent4 !== Ent4Rst) begin
      failures++;
      $display("FAIL reset_ent4 got=%h want=%h", ent4, Ent4Rst);
    end
    reset = 1'b0;
  endtask

  task automatic test_lfsr();
    logic [7:0] q;
    logic [7:0] first [4];
    int         n;
    first[0] = 8'h02; first[1] = 8'h04; first[2] = 8'h08; first[3] = 8'h11;
    q = 8'h01;
    n = $urandom_range(10, 30);
    for (int k = 0; k < n; k++) begin
      tick();
      q = ref_lfsr(q);
`ifdef CPU_IO_LFSR_EN
      if (k < 4) begin
        checks++;
        if (ent4 !== first[k]) begin
          failures++;
          $display("FAIL lfsr_start step=%0d got=%h want=%h", k, ent4, first[k]);
        end
      end
      checks++;
      if (ent4 !== q) begin
        failures++;
        $display("FAIL lfsr_seq step=%0d got=%h want=%h", k, ent4, q);
      end
`else
      checks++;
      if (ent4 !== 8'h00) begin
        failures++;
        $display("FAIL lfsr_off step=%0d got=%h want=00", k, ent4);
      end
`endif
    end
  endtask

  task automatic test_leds();
    logic [7:0] v, prev;
    for (int k = 0; k < 6; k++) begin
      prev = leds;
      v = 8'($urandom);
      sal1 = v;
      #1;
      checks++;
      if (leds !== prev) begin
        failures++;
        $display("FAIL leds_comb got=%h want=%h", leds, prev);
      end
      tick();
      checks++;
      if (leds !== v) begin
        failures++;
        $display("FAIL leds_reg got=%h want=%h", leds, v);
      end
    end
  endtask

  task automatic test_key(input logic [3:0] mask);
    int lat;
    btn = mask;
    wait_ent2(lat);
    checks++;
    if (lat != KeyLat) begin
      failures++;
      $display("FAIL key_lat mask=%b got=%0d want=%0d", mask, lat, KeyLat);
    end
    checks++;
    if (ent1 !== {6'b0, ref_code(mask)}) begin
      failures++;
      $display("FAIL key_code mask=%b got=%h want=%h", mask, ent1, {6'b0, ref_code(mask)});
    end
    sal2 = 8'($urandom) | 8'h01;
    tick();
    checks++;
    if (ent2 !== 8'h00) begin
      failures++;
      $display("FAIL key_ack got=%h want=00", ent2);
    end
    sal2 = 8'($urandom) & 8'hFE;
    tick();
    sal2 = 8'h00;
    btn  = 4'b0000;
    repeat (Deb + 6) tick();
    checks++;
    if (ent2 !== 8'h00 || ent1 !== {6'b0, ref_code(mask)}) begin
      failures++;
      $display("FAIL key_idle got=%h/%h want=00/%h", ent2, ent1, {6'b0, ref_code(mask)});
    end
  endtask

  task automatic test_key_random();
    logic [3:0] m;
    for (int k = 0; k < 4; k++) begin
      m = 4'($urandom_range(1, 15));
      test_key(m);
    end
  endtask

  task automatic test_drop();
    int lat;
    btn = 4'b1010;
    wait_ent2(lat);
    checks++;
    if (ent1 !== 8'h01) begin
      failures++;
      $display("FAIL drop_pick got=%h want=01", ent1);
    end
    btn = 4'b1011;
    repeat (20) tick();
    sal2 = 8'h01;
    tick();
    sal2 = 8'h00;
    tick();
    repeat (12) tick();
    checks++;
    if (ent1 !== 8'h01 || ent2 !== 8'h00) begin
      failures++;
      $display("FAIL drop_full got=%h/%h want=01/00", ent1, ent2);
    end
    btn = 4'b0000;
    repeat (Deb + 6) tick();
  endtask

  task automatic test_glitch();
    bit seen;
    seen = 1'b0;
    btn = 4'b0001;
    repeat (3) tick();
    btn = 4'b0000;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ent2 !== 8'h00) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL glitch got=event want=none");
    end
  endtask

  task automatic test_timer_plan();
    int lat;
    sal3 = 8'h00;
    tick();
    sal3 = 8'h83;
    lat = 0;
    wait_ent3(lat);
    checks++;
    if (lat != ref_timer_lat(3)) begin
      failures++;
      $display("FAIL timer_plan got=%0d want=%0d", lat, ref_timer_lat(3));
    end
    sal3 = 8'h00;
    tick();
    sal3 = 8'h83;
    repeat (14) tick();
    sal3 = 8'h02;
    tick();
    sal3 = 8'h82;
    lat = 0;
    wait_ent3(lat);
    checks++;
    if (lat != ref_timer_lat(2)) begin
      failures++;
      $display("FAIL timer_rearm got=%0d want=%0d", lat, ref_timer_lat(2));
    end
  endtask

  task automatic test_timer_random();
    int lat, n;
    for (int k = 0; k < 5; k++) begin
      n = $urandom_range(0, 6);
      sal3 = 8'h00;
      tick();
      sal3 = {1'b1, 7'(n)};
      tick();
      lat = 1;
      checks++;
      if (ent3 !== 8'h00) begin
        failures++;
        $display("FAIL timer_clear n=%0d got=%h want=00", n, ent3);
      end
      wait_ent3(lat);
      checks++;
      if (lat != ref_timer_lat(n)) begin
        failures++;
        $display("FAIL timer_lat n=%0d got=%0d want=%0d", n, lat, ref_timer_lat(n));
      end
      repeat (5) tick();
      checks++;
      if (ent3 !== 8'h80) begin
        failures++;
        $display("FAIL timer_hold n=%0d got=%h want=80", n, ent3);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    sal1 = 8'hA5;
    sal3 = 8'h00;
    tick();
    sal3 = 8'h85;
    btn  = 4'b0100;
    wait_ent2(lat);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (ent1 !== 8'h00 || ent2 !== 8'h00 || ent3 !== 8'h00 || leds !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid got=%h/%h/%h/%h want=00/00/00/00", ent1, ent2, ent3, leds);
    end
    checks++;
    if (ent4 !== Ent4Rst) begin
      failures++;
      $display("FAIL reset_mid_ent4 got=%h want=%h", ent4, Ent4Rst);
    end
    sal3 = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    wait_ent2(lat);
    checks++;
    if (lat != KeyLat || ent1 !== 8'h02) begin
      failures++;
      $display("FAIL reset_rehold got=%0d/%h want=%0d/02", lat, ent1, KeyLat);
    end
  endtask

  initial begin
    reset = 1'b1;
    btn   = 4'b0000;
    sal1  = 8'h00;
    sal2  = 8'h00;
    sal3  = 8'h00;
    sal4  = 8'h00;
    repeat (3) tick();
    test_reset();
    test_lfsr();
    test_leds();
    sal4 = 8'hFF;
    test_key(4'b0100);
    test_key_random();
    test_drop();
    test_glitch();
    test_timer_plan();
    test_timer_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
